dmem_resp: RTL and testbench
============================

// Module: dmem_resp
// PURPOSE
//  Data-memory responder for the data_path load/store port (addr_data, write_data, we, read_data).
//  Replaces the zero-wait combinational RAM with a registered, wait-stated responder.
//  Adds a req/ready handshake so the core stalls while an access is in flight.
//  Holds DEPTH 32-bit words; word-addressed via addr[31:2].
// PARAMETERS
//  DEPTH   64  number of 32-bit words; power of two, >= 2
//  LAT     2   wait cycles between accept and response, 0..15
// PORTS
//  clk         in   1   single clock; all state updates on posedge
//  reset       in   1   synchronous, active-low; sampled on posedge clk
//  req         in   1   core requests an access this cycle
//  we          in   1   1 = store, 0 = load; qualified by req
//  addr        in   32  byte address; word index addr[31:2]
//  write_data  in   32  store data; qualified by req & we
//  ready       out  1   high for exactly one cycle when the access completes
//  read_data   out  32  load result; valid while ready=1 and the access was a load
//  busy        out  1   access accepted and not yet completed; core stall signal
//  err         out  1   high with ready if the access was rejected (DMEM_RESP_CHK_EN only)
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, ready=0, busy=0, err=0, read_data=0, cnt=0. RAM contents are not cleared.
//  Reset mid-access aborts the access; a pending store is NOT written.
//  FSM states: IDLE, WAIT, RESP.
//   IDLE: if req, latch we/addr/write_data, set cnt=LAT, busy=1; go WAIT if LAT>0, else go RESP.
//   WAIT: cnt decrements each cycle; on cnt==1, go RESP. req is ignored (busy=1).
//   RESP (one cycle): ready=1, busy=0. Store: RAM[idx]<=wdata on entry to RESP. Load: read_data=RAM[idx].
//        If req is high in RESP, the new access is accepted (back-to-back); next state as from IDLE.
//  Latency: accept at edge N -> ready high in cycle N+LAT+1.
//  read_data holds its last load value outside RESP; it is not updated by stores.
//  Index wrap: idx = addr[$clog2(DEPTH)+1:2]; upper bits are ignored when checking is off.
//  Store then load to the same word: the load returns the new data (the store has committed by RESP).
//  we/addr/write_data changing after accept have no effect (latched).
// CONFIGURATION
//  DMEM_RESP_CHK_EN defined: an access is rejected if addr[1:0]!=0 or addr[31:2]>=DEPTH;
//   rejected -> err=1 with ready, no RAM write, read_data=0; timing identical to a normal access.
//  Not defined: no checks; err is tied 0; misaligned addresses are truncated; out-of-range addresses wrap.
// STRUCTURE
//  Shared package dmem_pkg: state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), DMEM_WORD_W=32,
//   DMEM_DEPTH_DEF=64, DMEM_LAT_DEF=2.
//  Sub-module dmem_array: DEPTH x 32 synchronous-write RAM with write port (we, idx, wdata)
//   and a registered read port. dmem_resp holds the FSM, counter, latches and checks only.
// TESTING
//  1. Reset: hold reset=0 for 3 cycles with req=1 -> ready=0, busy=0, err=0, read_data=0; no RAM write.
//  2. Store/load, LAT=2: store 0xDEADBEEF to 0x10, then load 0x10 -> each ready 3 cycles after accept;
//     load read_data=0xDEADBEEF; busy high for 2 cycles each.
//  3. Back-to-back: req held high for 4 loads of 0x0,0x4,0x8,0xC (preloaded 1..4) -> ready every LAT+1
//     cycles; read_data 1,2,3,4 in order; no access dropped.
//  4. LAT=0: store 0x5A to 0x20 then load 0x20 -> ready the cycle after each accept; read_data=0x5A.
//  5. Reset mid-access: accept store 0x1234 to 0x8, assert reset in WAIT -> FSM IDLE; a later load of 0x8
//     returns its old value.
//  6. CHK_EN: load 0x3 and store 0x100 (DEPTH=64) -> err=1 with ready, read_data=0, RAM[0] unchanged;
//     without CHK_EN: store 0x100 writes RAM[0].

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and defaults for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} dmem_state_t;
  localparam int DMEM_WORD_W = 32;
  localparam int DMEM_DEPTH_DEF = 64;
  localparam int DMEM_LAT_DEF = 2;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 RAM, synchronous write, registered read with zero-on-reject
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic                   re,
  input  logic                   clr,
  input  logic [AW-1:0]          idx,
  input  logic [DMEM_WORD_W-1:0] wdata,
  output logic [DMEM_WORD_W-1:0] rdata
);
  logic [DMEM_WORD_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (reset && we) mem[idx] <= wdata;
  // rdata only moves on loads or rejects, so it holds the last load value otherwise
  always_ff @(posedge clk)
    if (!reset) rdata <= '0;
    else if (re) rdata <= clr ? '0 : mem[idx];
endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: wait-stated data-memory responder with req/ready handshake; DMEM_RESP_CHK_EN enables address checks
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH_DEF,
  parameter int LAT = DMEM_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic                   we,
  input  logic [31:0]            addr,
  input  logic [DMEM_WORD_W-1:0] write_data,
  output logic                   ready,
  output logic [DMEM_WORD_W-1:0] read_data,
  output logic                   busy,
  output logic                   err
);
  localparam int AW = $clog2(DEPTH);
  dmem_state_t state, state_nx;
  logic [3:0] cnt;
  logic we_q, bad_q, rej_q;
  logic [AW-1:0] idx_q;
  logic [DMEM_WORD_W-1:0] wdata_q;
  logic acc, fire, bad_in, op_we, op_bad;
  logic [AW-1:0] op_idx;
  logic [DMEM_WORD_W-1:0] op_wdata;
`ifdef DMEM_RESP_CHK_EN
  assign bad_in = (|addr[1:0]) || (|addr[31:AW+2]);
`else
  logic unused_addr;
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
  assign bad_in = 1'b0;
`endif
  assign acc = req && (state == IDLE || state == RESP);
  // with zero latency the access commits on its accept edge, straight from the inputs
  assign fire = (LAT == 0) ? acc : (state == WAIT && cnt == 4'd1);
  assign op_we = (LAT == 0) ? we : we_q;
  assign op_bad = (LAT == 0) ? bad_in : bad_q;
  assign op_idx = (LAT == 0) ? addr[AW+1:2] : idx_q;
  assign op_wdata = (LAT == 0) ? write_data : wdata_q;
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : acc ? (LAT > 0 ? WAIT : RESP) : IDLE;
  end
  always_comb begin
    ready = state == RESP;
    busy = state == WAIT;
    err = state == RESP && rej_q;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      cnt <= '0;
      we_q <= 1'b0;
      bad_q <= 1'b0;
      rej_q <= 1'b0;
      idx_q <= '0;
      wdata_q <= '0;
    end else begin
      if (acc) begin
        cnt <= 4'(LAT);
        we_q <= we;
        bad_q <= bad_in;
        idx_q <= addr[AW+1:2];
        wdata_q <= write_data;
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      if (fire) rej_q <= op_bad;
    end
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk(clk),
    .reset(reset),
    .we(fire && op_we && !op_bad),
    .re(fire && (!op_we || op_bad)),
    .clr(op_bad),
    .idx(op_idx),
    .wdata(op_wdata),
    .rdata(read_data)
  );
endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: scoreboard bench for dmem_resp at LAT=2 (dut a) and LAT=0 (dut b)
module tb_dmem_resp;
  localparam int DEPTH = 64;
`ifdef DMEM_RESP_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic req_a, we_a, ready_a, busy_a, err_a;
  logic req_b, we_b, ready_b, busy_b, err_b;
  logic [31:0] addr_a, wd_a, rd_a, addr_b, wd_b, rd_b;
  int unsigned cyc = 0;
  int vectors = 0, miscompares = 0;
  typedef struct {
    int unsigned cyc;
    bit we;
    bit bad;
    logic [5:0] idx;
    logic [31:0] wd;
    logic [31:0] rd;
  } exp_t;
  exp_t q_a[$], q_b[$];
  logic [31:0] m_a [DEPTH];
  logic [31:0] m_b [DEPTH];
  logic [31:0] last_a = '0, last_b = '0;

  dmem_resp #(.DEPTH(DEPTH), .LAT(2)) u_dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a), .write_data(wd_a),
    .ready(ready_a), .read_data(rd_a), .busy(busy_a), .err(err_a));
  dmem_resp #(.DEPTH(DEPTH), .LAT(0)) u_dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b), .write_data(wd_b),
    .ready(ready_b), .read_data(rd_b), .busy(busy_b), .err(err_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int qs(input bit d);
    return d ? q_b.size() : q_a.size();
  endfunction

  task automatic pop(input bit d);
    exp_t e;
    string p;
    p = d ? "b" : "a";
    if (qs(d) == 0) begin
      chk({p, "_spurious_ready"}, 32'(qs(d)), 32'd1);
      return;
    end
    e = d ? q_b.pop_front() : q_a.pop_front();
    chk({p, "_latency"}, cyc, e.cyc);
    chk({p, "_read_data"}, d ? rd_b : rd_a, e.rd);
    chk({p, "_err"}, 32'(d ? err_b : err_a), 32'(e.bad));
    chk({p, "_busy_in_resp"}, 32'(d ? busy_b : busy_a), 32'd0);
    if (e.we && !e.bad) begin
      if (d) m_b[e.idx] = e.wd;
      else m_a[e.idx] = e.wd;
    end
  endtask

  always @(negedge clk) if (reset && ready_a) pop(1'b0);
  always @(negedge clk) if (reset && ready_b) pop(1'b1);

  task automatic drive(input bit d, input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd);
    if (d) begin
      req_b = r; we_b = w; addr_b = a; wd_b = wd;
    end else begin
      req_a = r; we_a = w; addr_a = a; wd_a = wd;
    end
  endtask

  // drives a request now; it is accepted at the next posedge, then the expectation is queued
  task automatic issue(input bit d, input logic w, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    e.bad = CHK && (a[1:0] != 2'd0 || a[31:2] >= DEPTH);
    e.we = w;
    e.idx = a[7:2];
    e.wd = wd;
    drive(d, 1'b1, w, a, wd);
    @(posedge clk);
    #1;
    e.cyc = cyc + (d ? 0 : 2);
    if (e.bad) e.rd = '0;
    else if (w) e.rd = d ? last_b : last_a;
    else e.rd = d ? m_b[e.idx] : m_a[e.idx];
    if (e.bad || !w) begin
      if (d) last_b = e.rd;
      else last_a = e.rd;
    end
    if (d) q_b.push_back(e);
    else q_a.push_back(e);
  endtask

  task automatic drain(input bit d);
    drive(d, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 20 && qs(d) != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk(d ? "b_drain_timeout" : "a_drain_timeout", 32'(qs(d)), 32'd0);
    if (d) q_b.delete();
    else q_a.delete();
  endtask

  // holds reset with a store request pending on both duts; nothing may reach the RAM
  task automatic do_reset(input int n);
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 32'h14, 32'h0BAD);
    drive(1'b1, 1'b1, 1'b1, 32'h14, 32'h0BAD);
    repeat (n) begin
      @(negedge clk);
      chk("rst_ready_a", 32'(ready_a), 32'd0);
      chk("rst_busy_a", 32'(busy_a), 32'd0);
      chk("rst_err_a", 32'(err_a), 32'd0);
      chk("rst_rdata_a", rd_a, 32'd0);
      chk("rst_ready_b", 32'(ready_b), 32'd0);
      chk("rst_rdata_b", rd_b, 32'd0);
    end
    q_a.delete();
    q_b.delete();
    last_a = '0;
    last_b = '0;
    #1;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_a[i] = '0;
      m_b[i] = '0;
    end
    do_reset(3);
    issue(1'b0, 1'b1, 32'h14, 32'h600D);
    drain(1'b0);
    do_reset(3);
    issue(1'b0, 1'b0, 32'h14, '0);
    drain(1'b0);
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, i == 0, 32'h10, 32'hDEADBEEF);
      chk("a_busy_wait1", 32'(busy_a), 32'd1);
      @(posedge clk);
      #1;
      chk("a_busy_wait2", 32'(busy_a), 32'd1);
      @(posedge clk);
      #1;
      chk("a_busy_resp", 32'(busy_a), 32'd0);
      drain(1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b1, 32'(i * 4), 32'(i + 1));
      drain(1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b0, 32'(i * 4), '0);
      if (i < 3) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
    drain(1'b0);
    issue(1'b1, 1'b1, 32'h20, 32'h5A);
    drain(1'b1);
    issue(1'b1, 1'b0, 32'h20, '0);
    drain(1'b1);
    issue(1'b1, 1'b1, 32'h24, 32'h66);
    issue(1'b1, 1'b0, 32'h24, '0);
    drain(1'b1);
    issue(1'b0, 1'b1, 32'h8, 32'h1234);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_ready", 32'(ready_a), 32'd0);
    q_a.delete();
    last_a = '0;
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    issue(1'b0, 1'b0, 32'h8, '0);
    drain(1'b0);
    issue(1'b0, 1'b0, 32'h3, '0);
    drain(1'b0);
    issue(1'b0, 1'b1, 32'h100, 32'h77);
    drain(1'b0);
    issue(1'b0, 1'b0, 32'h0, '0);
    drain(1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
